// File: rtl/netdma_mm_arbiter.sv
// Shares one Avalon-MM master between a read-only and a write-only requester; commands and read data pass with zero latency.
// Backpressure: losers see waitrequest=1, a stalled grant is locked until accepted, and reads are masked at MAX_PENDING.
`timescale 1ns/1ps
module netdma_mm_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_PENDING = 4,
    parameter int MAX_RUN     = 8,
    localparam int BE_W = DATA_WIDTH / 8,
    localparam int PW   = $clog2(MAX_PENDING + 1),
    localparam int RW   = $clog2(MAX_RUN + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_read_i,
    input  logic [ADDR_WIDTH-1:0] rd_address_i,
    output logic                  rd_waitrequest_o,
    output logic [DATA_WIDTH-1:0] rd_readdata_o,
    output logic                  rd_readdatavalid_o,
    input  logic                  wr_write_i,
    input  logic [ADDR_WIDTH-1:0] wr_address_i,
    input  logic [DATA_WIDTH-1:0] wr_writedata_i,
    input  logic [BE_W-1:0]       wr_byteenable_i,
    output logic                  wr_waitrequest_o,
    output logic [ADDR_WIDTH-1:0] avm_address_o,
    output logic                  avm_read_o,
    output logic                  avm_write_o,
    output logic [DATA_WIDTH-1:0] avm_writedata_o,
    output logic [BE_W-1:0]       avm_byteenable_o,
    input  logic                  avm_waitrequest_i,
    input  logic [DATA_WIDTH-1:0] avm_readdata_i,
    input  logic                  avm_readdatavalid_i,
    output logic [PW-1:0]         rd_pending_o,
    output logic                  err_o
);
    typedef enum logic {OWN_RD = 1'b0, OWN_WR = 1'b1} owner_e;

    logic          lock_q, lock_d;
    owner_e        lock_owner_q, lock_owner_d;
    owner_e        last_q, last_d;
    logic [RW-1:0] run_q, run_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          err_q, err_d;

    logic   rd_elig, wr_elig, gnt_vld, gnt_rd, gnt_wr;
    logic   accept, rd_accept, rsp_ok;
    owner_e gnt_own;

    // run_q==0 only right after reset, so the first tie goes to the side opposite last_q (RD)
    always_comb begin
        rd_elig = rd_read_i && (pend_q < PW'(MAX_PENDING));
        wr_elig = wr_write_i;
        gnt_vld = 1'b0;
        gnt_own = OWN_RD;
        if (rst_i) begin
            gnt_vld = 1'b0;
        end else if (lock_q) begin
            gnt_own = lock_owner_q;
            gnt_vld = (lock_owner_q == OWN_RD) ? rd_read_i : wr_write_i;
        end else if (rd_elig && wr_elig) begin
            gnt_vld = 1'b1;
            if (run_q != '0 && run_q < RW'(MAX_RUN)) begin
                gnt_own = last_q;
            end else begin
                gnt_own = (last_q == OWN_RD) ? OWN_WR : OWN_RD;
            end
        end else if (rd_elig) begin
            gnt_vld = 1'b1;
            gnt_own = OWN_RD;
        end else if (wr_elig) begin
            gnt_vld = 1'b1;
            gnt_own = OWN_WR;
        end
        gnt_rd = gnt_vld && (gnt_own == OWN_RD);
        gnt_wr = gnt_vld && (gnt_own == OWN_WR);
    end

    always_comb begin
        accept       = gnt_vld && !avm_waitrequest_i;
        rd_accept    = accept && gnt_rd;
        rsp_ok       = avm_readdatavalid_i && (pend_q != '0);
        lock_d       = gnt_vld && avm_waitrequest_i;
        lock_owner_d = lock_d ? gnt_own : lock_owner_q;
        last_d       = last_q;
        run_d        = run_q;
        if (accept) begin
            if (gnt_own == last_q) begin
                if (run_q < RW'(MAX_RUN)) begin
                    run_d = run_q + RW'(1);
                end
            end else begin
                run_d  = RW'(1);
                last_d = gnt_own;
            end
        end
        pend_d = pend_q;
        if (rd_accept && !rsp_ok) begin
            pend_d = pend_q + PW'(1);
        end else if (!rd_accept && rsp_ok) begin
            pend_d = pend_q - PW'(1);
        end
        err_d = err_q || (avm_readdatavalid_i && (pend_q == '0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_RD;
            last_q       <= OWN_WR;
            run_q        <= '0;
            pend_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            last_q       <= last_d;
            run_q        <= run_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        avm_read_o       = gnt_rd;
        avm_write_o      = gnt_wr;
        avm_address_o    = '0;
        avm_writedata_o  = '0;
        avm_byteenable_o = '0;
        if (gnt_rd) begin
            avm_address_o    = rd_address_i;
            avm_byteenable_o = {BE_W{1'b1}};
        end else if (gnt_wr) begin
            avm_address_o    = wr_address_i;
            avm_writedata_o  = wr_writedata_i;
            avm_byteenable_o = wr_byteenable_i;
        end
    end

    assign rd_waitrequest_o   = !gnt_rd || avm_waitrequest_i;
    assign wr_waitrequest_o   = !gnt_wr || avm_waitrequest_i;
    assign rd_readdata_o      = avm_readdata_i;
    assign rd_readdatavalid_o = avm_readdatavalid_i;
    assign rd_pending_o       = pend_q;
    assign err_o              = err_q;
endmodule

// File: tb/tb_netdma_mm_arbiter.sv
// Bench for netdma_mm_arbiter: directed scenarios with literal expectations plus a per-cycle reference model.
`timescale 1ns/1ps
module tb_netdma_mm_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MP = 4;
    localparam int MR = 8;
    localparam int BW = DW / 8;
    localparam int PW = $clog2(MP + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          rd_read_i = 1'b0;
    logic [AW-1:0] rd_address_i = '0;
    logic          rd_waitrequest_o;
    logic [DW-1:0] rd_readdata_o;
    logic          rd_readdatavalid_o;
    logic          wr_write_i = 1'b0;
    logic [AW-1:0] wr_address_i = '0;
    logic [DW-1:0] wr_writedata_i = '0;
    logic [BW-1:0] wr_byteenable_i = '0;
    logic          wr_waitrequest_o;
    logic [AW-1:0] avm_address_o;
    logic          avm_read_o;
    logic          avm_write_o;
    logic [DW-1:0] avm_writedata_o;
    logic [BW-1:0] avm_byteenable_o;
    logic          avm_waitrequest_i = 1'b0;
    logic [DW-1:0] avm_readdata_i = '0;
    logic          avm_readdatavalid_i = 1'b0;
    logic [PW-1:0] rd_pending_o;
    logic          err_o;

    netdma_mm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PENDING(MP), .MAX_RUN(MR)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_read_i(rd_read_i), .rd_address_i(rd_address_i), .rd_waitrequest_o(rd_waitrequest_o),
        .rd_readdata_o(rd_readdata_o), .rd_readdatavalid_o(rd_readdatavalid_o),
        .wr_write_i(wr_write_i), .wr_address_i(wr_address_i), .wr_writedata_i(wr_writedata_i),
        .wr_byteenable_i(wr_byteenable_i), .wr_waitrequest_o(wr_waitrequest_o),
        .avm_address_o(avm_address_o), .avm_read_o(avm_read_o), .avm_write_o(avm_write_o),
        .avm_writedata_o(avm_writedata_o), .avm_byteenable_o(avm_byteenable_o),
        .avm_waitrequest_i(avm_waitrequest_i), .avm_readdata_i(avm_readdata_i),
        .avm_readdatavalid_i(avm_readdatavalid_i), .rd_pending_o(rd_pending_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    // Reference model: history of accepted owners (0=RD, 1=WR), outstanding-read count, stalled command
    int  hist[$];
    int  m_pend = 0;
    bit  m_err = 1'b0;
    bit  st_vld = 1'b0;
    int  st_own = 0;
    bit  model_on = 1'b0;
    bit  e_rd, e_wr, rd_ok;
    int  streak, last_own;

    always @(negedge clk_i) begin
        if (model_on) begin
            e_rd = 1'b0;
            e_wr = 1'b0;
            if (!rst_i) begin
                if (st_vld) begin
                    if (st_own == 0) e_rd = rd_read_i;
                    else e_wr = wr_write_i;
                end else begin
                    rd_ok = rd_read_i && (m_pend < MP);
                    if (rd_ok && wr_write_i) begin
                        if (hist.size() == 0) begin
                            e_rd = 1'b1;
                        end else begin
                            last_own = hist[hist.size()-1];
                            streak = 0;
                            for (int i = hist.size() - 1; i >= 0 && hist[i] == last_own; i--) streak++;
                            if ((streak < MR) == (last_own == 0)) e_rd = 1'b1;
                            else e_wr = 1'b1;
                        end
                    end else begin
                        e_rd = rd_ok;
                        e_wr = wr_write_i;
                    end
                end
            end
            chk("m_read", avm_read_o, e_rd);
            chk("m_write", avm_write_o, e_wr);
            chk("m_rd_wait", rd_waitrequest_o, !e_rd || avm_waitrequest_i);
            chk("m_wr_wait", wr_waitrequest_o, !e_wr || avm_waitrequest_i);
            if (e_rd) begin
                chk("m_rd_addr", avm_address_o, rd_address_i);
                chk("m_rd_be", avm_byteenable_o, {BW{1'b1}});
                chk("m_rd_wdata", avm_writedata_o, 0);
            end
            if (e_wr) begin
                chk("m_wr_addr", avm_address_o, wr_address_i);
                chk("m_wr_be", avm_byteenable_o, wr_byteenable_i);
                chk("m_wr_wdata", avm_writedata_o, wr_writedata_i);
            end
            chk("m_rdv", rd_readdatavalid_o, avm_readdatavalid_i);
            chk("m_rdata", rd_readdata_o, avm_readdata_i);
            chk("m_pending", rd_pending_o, m_pend);
            chk("m_err", err_o, m_err);
            if (rst_i) begin
                hist.delete();
                m_pend = 0;
                m_err  = 1'b0;
                st_vld = 1'b0;
            end else begin
                if (avm_readdatavalid_i) begin
                    if (m_pend == 0) m_err = 1'b1;
                    else m_pend--;
                end
                if ((e_rd || e_wr) && avm_waitrequest_i) begin
                    st_vld = 1'b1;
                    st_own = e_wr ? 1 : 0;
                end else begin
                    st_vld = 1'b0;
                    if (e_rd || e_wr) begin
                        hist.push_back(e_wr ? 1 : 0);
                        if (hist.size() > MR) void'(hist.pop_front());
                        if (e_rd) m_pend++;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
        $fatal(1);
    end

    bit prev;

    initial begin
        tick();
        rst_i    = 1'b0;
        model_on = 1'b1;

        // Single read
        rd_read_i = 1'b1; rd_address_i = 32'h100;
        smp();
        chk("t1_read", avm_read_o, 1);
        chk("t1_addr", avm_address_o, 32'h100);
        chk("t1_pend0", rd_pending_o, 0);
        tick(); rd_read_i = 1'b0;
        smp(); chk("t1_pend1", rd_pending_o, 1);
        tick(); avm_readdatavalid_i = 1'b1; avm_readdata_i = 64'hDEADBEEF;
        smp();
        chk("t1_rdv", rd_readdatavalid_o, 1);
        chk("t1_rdata", rd_readdata_o, 64'hDEADBEEF);
        tick(); avm_readdatavalid_i = 1'b0;
        smp(); chk("t1_pend_back0", rd_pending_o, 0);

        // Contention from reset: 8 RD, 8 WR, 8 RD
        tick(); rst_i = 1'b1;
        tick(); rst_i = 1'b0;
        rd_read_i = 1'b1; wr_write_i = 1'b1;
        rd_address_i = 32'h300; wr_address_i = 32'h400;
        wr_writedata_i = 64'hCAFE_0000_1234_5678; wr_byteenable_i = 8'hF0;
        prev = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) tick();
            avm_readdatavalid_i = prev;
            avm_readdata_i = 64'(i);
            smp();
            prev = avm_read_o && !avm_waitrequest_i;
            chk("t2_order_wr", avm_write_o, (i >= 8 && i < 16));
            chk("t2_order_rd", avm_read_o, !(i >= 8 && i < 16));
        end
        tick(); rd_read_i = 1'b0; wr_write_i = 1'b0; avm_readdatavalid_i = prev;
        smp();
        tick(); avm_readdatavalid_i = 1'b0;
        smp(); chk("t2_pend_drained", rd_pending_o, 0);

        // Pending limit
        tick(); rd_read_i = 1'b1; rd_address_i = 32'h500;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            smp(); chk("t3_rd_acc", avm_read_o, 1);
        end
        tick(); wr_write_i = 1'b1; wr_address_i = 32'h600;
        smp();
        chk("t3_pend4", rd_pending_o, 4);
        chk("t3_rd_wait", rd_waitrequest_o, 1);
        chk("t3_no_read", avm_read_o, 0);
        chk("t3_write", avm_write_o, 1);
        tick(); wr_write_i = 1'b0; avm_readdatavalid_i = 1'b1;
        smp(); chk("t3_still_blocked", avm_read_o, 0);
        tick(); avm_readdatavalid_i = 1'b0;
        smp();
        chk("t3_reenabled", avm_read_o, 1);
        chk("t3_pend3", rd_pending_o, 3);
        tick(); rd_read_i = 1'b0; avm_readdatavalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            smp();
        end
        tick(); avm_readdatavalid_i = 1'b0;
        smp(); chk("t3_pend_drained", rd_pending_o, 0);

        // Stall lock on a write while RD waits
        tick();
        wr_write_i = 1'b1; wr_address_i = 32'hA0;
        wr_writedata_i = 64'h1122334455667788; wr_byteenable_i = 8'h0F;
        avm_waitrequest_i = 1'b1; rd_address_i = 32'h700;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                rd_read_i = 1'b1;
            end
            smp();
            chk("t4_write_held", avm_write_o, 1);
            chk("t4_addr_held", avm_address_o, 32'hA0);
            chk("t4_data_held", avm_writedata_o, 64'h1122334455667788);
            chk("t4_rd_blocked", rd_waitrequest_o, 1);
        end
        tick(); avm_waitrequest_i = 1'b0;
        smp();
        chk("t4_wr_accept", wr_waitrequest_o, 0);
        chk("t4_rd_wait_at_accept", rd_waitrequest_o, 1);
        tick(); wr_write_i = 1'b0;
        smp();
        chk("t4_rd_after", avm_read_o, 1);
        chk("t4_rd_addr", avm_address_o, 32'h700);

        // Read accept and readdatavalid together at pending=2
        tick();
        smp(); chk("t5_pend1", rd_pending_o, 1);
        tick(); avm_readdatavalid_i = 1'b1; avm_readdata_i = 64'h55;
        smp();
        chk("t5_pend2", rd_pending_o, 2);
        chk("t5_read", avm_read_o, 1);
        tick(); rd_read_i = 1'b0; avm_readdatavalid_i = 1'b0;
        smp(); chk("t5_pend_same", rd_pending_o, 2);
        tick(); avm_readdatavalid_i = 1'b1;
        smp();
        tick();
        smp();
        tick(); avm_readdatavalid_i = 1'b0;
        smp(); chk("t5_pend_drained", rd_pending_o, 0);

        // Spurious readdatavalid, sticky error, reset
        tick(); avm_readdatavalid_i = 1'b1;
        smp(); chk("t6_err_before", err_o, 0);
        tick(); avm_readdatavalid_i = 1'b0;
        smp();
        chk("t6_err_set", err_o, 1);
        chk("t6_pend_zero", rd_pending_o, 0);
        tick();
        smp(); chk("t6_err_sticky", err_o, 1);
        tick(); rst_i = 1'b1; rd_read_i = 1'b1; wr_write_i = 1'b1;
        smp();
        chk("t6_rst_read", avm_read_o, 0);
        chk("t6_rst_write", avm_write_o, 0);
        chk("t6_rst_rd_wait", rd_waitrequest_o, 1);
        chk("t6_rst_wr_wait", wr_waitrequest_o, 1);
        tick(); rst_i = 1'b0;
        smp();
        chk("t6_err_cleared", err_o, 0);
        chk("t6_pend_cleared", rd_pending_o, 0);
        chk("t6_tie_rd", avm_read_o, 1);
        chk("t6_tie_no_wr", avm_write_o, 0);
        tick(); rd_read_i = 1'b0; wr_write_i = 1'b0;
        smp();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
